fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DW, default 8, data width (matches FIFO data_in width).
REQ-003 Parameter MAXLEN, default 16, maximum beats per grant before forced release.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request; bit i held high while requester i has a packet.
REQ-007 data  input  NREQ*DW  packed per-requester write data; slice i = data[i*DW +: DW].
REQ-008 last  input  NREQ  per-requester end-of-packet marker, valid with the beat it accompanies.
REQ-009 gnt  output  NREQ  one-hot grant; zero when idle.
REQ-010 ack  output  NREQ  one-hot beat-accepted pulse; requester advances its data on ack.
REQ-011 fifo_full  input  1  full flag from the shared FIFO.
REQ-012 fifo_wr_en  output  1  write enable to the shared FIFO.
REQ-013 fifo_data  output  DW  write data to the shared FIFO.
REQ-014 err_drop  output  1  one-cycle pulse: owner dropped req before last.
REQ-015 err_maxlen  output  1  one-cycle pulse: grant force-released at MAXLEN beats.

Function
REQ-016 FSM states IDLE and BUSY; registers: state, owner index, last_served index, beat counter (clog2(MAXLEN+1) bits).
REQ-017 IDLE: if any req bit is high, select the first set bit searching upward (modulo NREQ) from last_served+1; next cycle state=BUSY, owner=selection, gnt=onehot(owner), beat counter=0.
REQ-018 IDLE with req==0: remain IDLE, gnt=0.
REQ-019 A beat transfers in BUSY when req[owner]=1 and fifo_full=0; in that cycle fifo_wr_en=1, fifo_data=data slice of owner, ack=onehot(owner) (all combinational, same cycle).
REQ-020 fifo_wr_en, ack and fifo_data shall never cause a write while fifo_full=1; data is not lost or duplicated, the owner simply stalls.
REQ-021 fifo_data shall be 0 whenever fifo_wr_en=0.
REQ-022 Each transferred beat increments the beat counter by 1.
REQ-023 Transfer with last[owner]=1: next state IDLE, last_served=owner, gnt=0 next cycle (one bubble cycle between grants).
REQ-024 Transfer without last that makes beat count equal MAXLEN: next state IDLE, last_served=owner, err_maxlen pulses one cycle (the cycle after the transfer).
REQ-025 BUSY with req[owner]=0: next state IDLE, last_served=owner, no write, err_drop pulses one cycle.
REQ-026 Requests from non-owners shall not affect BUSY state; they are considered only in IDLE.
REQ-027 last, data of non-owners and last of a non-transferring cycle are ignored.
REQ-028 Priority when several conditions coincide in one BUSY cycle: drop (REQ-025), then last (REQ-023), then MAXLEN (REQ-024); last and MAXLEN on the same beat gives normal release with no err_maxlen.
REQ-029 Round-robin fairness: with all requesters continuously requesting, each requester is granted exactly once per NREQ grants.

Reset
REQ-030 On rst: state=IDLE, owner=0, last_served=NREQ-1 (requester 0 has first priority), beat counter=0.
REQ-031 On rst all outputs immediately 0: gnt, ack, fifo_wr_en, fifo_data, err_drop, err_maxlen.
REQ-032 Reset asserted mid-packet aborts the grant with no further write; after deassertion arbitration restarts from requester 0.

Structure
REQ-033 Shared package holds state encoding (IDLE, BUSY) and default constants for NREQ, DW, MAXLEN.
REQ-034 One sub-module rr_pick: combinational, inputs req and last_served, outputs valid and selected index; no other sub-modules.

Verification
REQ-035 Reset then req=4'b0001, 3 beats A1,A2,A3 with last on A3, fifo_full=0 -> gnt=0001 one cycle after req, three writes A1..A3 on consecutive cycles, gnt=0 after A3.
REQ-036 req=4'b1111, every packet 1 beat -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-037 Owner 2 mid-packet, fifo_full=1 for 3 cycles -> fifo_wr_en=0 and ack=0 for those 3 cycles, next beat written once after full drops.
REQ-038 Owner 1 drops req after 2 beats -> no third write, err_drop pulses once, next grant goes to 2 if requesting.
REQ-039 MAXLEN=16, owner 0 never asserts last -> exactly 16 writes, err_maxlen pulse, requester 1 granted next.
REQ-040 rst asserted during beat 2 of a 5-beat packet -> outputs 0 immediately, no further writes; after release with req=1010, requester 1 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the FIFO write arbiter: the arbiter state encoding and
// the default values of the NREQ / DW / MAXLEN parameters.
// -----------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_NREQ   = 4;   // number of requesters (2..8)
    localparam int DEF_DW     = 8;   // FIFO data width
    localparam int DEF_MAXLEN = 16;  // beats per grant before forced release

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Finds the first set bit of req searching
// upward (modulo NREQ) starting at last_served+1.
//
// Ports
//   req          in   NREQ  request vector
//   last_served  in   IW    index of the requester served most recently
//   valid        out  1     at least one request is pending
//   sel          out  IW    selected requester index (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_served,
    output logic            valid,
    output logic [IW-1:0]   sel
);

    logic [IW-1:0] idx;

    // Walk the offsets from farthest to nearest so that the nearest requester
    // after last_served is the one left in sel when the loop ends.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        valid = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last_served) + k) % NREQ);
            if (req[idx]) begin
                valid = 1'b1;
                sel   = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that lets NREQ packet sources share one FIFO write port.
// A grant is held for a whole packet (until last), or until the owner drops its
// request, or until MAXLEN beats have been written. One idle cycle separates
// consecutive grants.
//
// Ports
//   clk         in   1        clock, rising edge
//   rst         in   1        asynchronous active-high reset
//   req         in   NREQ     per-requester request
//   data        in   NREQ*DW  per-requester data, slice i = data[i*DW +: DW]
//   last        in   NREQ     per-requester end-of-packet marker
//   gnt         out  NREQ     one-hot grant (registered), 0 when idle
//   ack         out  NREQ     one-hot beat-accepted pulse (combinational)
//   fifo_full   in   1        shared FIFO full flag
//   fifo_wr_en  out  1        shared FIFO write enable (combinational)
//   fifo_data   out  DW       shared FIFO write data, 0 when not writing
//   err_drop    out  1        pulse: owner dropped req before last
//   err_maxlen  out  1        pulse: grant force-released after MAXLEN beats
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NREQ   = DEF_NREQ,
    parameter  int DW     = DEF_DW,
    parameter  int MAXLEN = DEF_MAXLEN,
    localparam int IW     = $clog2(NREQ),
    localparam int CW     = $clog2(MAXLEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data,
    input  logic [NREQ-1:0]    last,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [DW-1:0]      fifo_data,
    output logic               err_drop,
    output logic               err_maxlen
);

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_served;
    logic [CW-1:0] beat_cnt;

    logic          pick_valid;
    logic [IW-1:0] pick_sel;
    logic          owner_req;
    logic          owner_last;
    logic          xfer;
    logic          at_max;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req         (req),
        .last_served (last_served),
        .valid       (pick_valid),
        .sel         (pick_sel)
    );

    assign owner_req  = req[owner];
    assign owner_last = last[owner];
    // A beat moves only while the owner still requests and the FIFO has room;
    // when full, the owner simply stalls with its current beat.
    assign xfer       = (state == BUSY) && owner_req && !fifo_full;
    // The beat being transferred now is the MAXLEN-th one.
    assign at_max     = (beat_cnt == CW'(MAXLEN - 1));

    // Write path is combinational so the owner sees ack in the same cycle the
    // beat enters the FIFO. Outputs fall to 0 with the async reset of state.
    always_comb begin
        ack        = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        if (xfer) begin
            ack        = NREQ'(1) << owner;
            fifo_wr_en = 1'b1;
            fifo_data  = data[owner*DW +: DW];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            last_served <= IW'(NREQ - 1);   // requester 0 wins first
            beat_cnt    <= '0;
            gnt         <= '0;
            err_drop    <= 1'b0;
            err_maxlen  <= 1'b0;
        end else begin
            err_drop   <= 1'b0;
            err_maxlen <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= BUSY;
                        owner    <= pick_sel;
                        gnt      <= NREQ'(1) << pick_sel;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    // Release priority: drop, then last, then MAXLEN.
                    if (!owner_req) begin
                        state       <= IDLE;
                        last_served <= owner;
                        gnt         <= '0;
                        err_drop    <= 1'b1;
                    end else if (!fifo_full) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (owner_last) begin
                            state       <= IDLE;
                            last_served <= owner;
                            gnt         <= '0;
                        end else if (at_max) begin
                            state       <= IDLE;
                            last_served <= owner;
                            gnt         <= '0;
                            err_maxlen  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (NREQ=4, DW=8, MAXLEN=16).
// Inputs are driven on the falling edge; outputs are compared 1 ns later,
// well away from the rising edge. Output bundle compared per cycle:
//   {gnt[3:0], ack[3:0], wr_en, err_drop, err_maxlen, fifo_data[7:0]}
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DW     = 8;
    localparam int MAXLEN = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data;
    logic              err_drop;
    logic              err_maxlen;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXLEN(MAXLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .last       (last),
        .gnt        (gnt),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .err_drop   (err_drop),
        .err_maxlen (err_maxlen)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       full;
        logic [31:0] data;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       wr;
        logic [7:0] fdata;
        logic       drop;
        logic       maxl;
    } vec_t;

    vec_t tbl[$];

    // ------------------------------------------------------------ helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [31:0] act_vec();
        return {13'b0, gnt, ack, fifo_wr_en, err_drop, err_maxlen, fifo_data};
    endfunction

    function automatic logic [31:0] mk_exp(logic [3:0] g, logic [3:0] a, logic w,
                                           logic dr, logic mx, logic [7:0] d);
        return {13'b0, g, a, w, dr, mx, d};
    endfunction

    // Data word with value v in slot s and filler in the other slots, so a
    // wrong slice selection shows up on fifo_data.
    function automatic logic [31:0] mk(int s, logic [7:0] v);
        logic [31:0] d;
        d = 32'hEEEE_EEEE;
        d[s*8 +: 8] = v;
        return d;
    endfunction

    function automatic vec_t v(bit r, logic [3:0] rq, logic [3:0] l, logic f, logic [31:0] d,
                               logic [3:0] g, logic [3:0] a, logic w, logic [7:0] fd);
        vec_t t;
        t = '{do_rst: r, req: rq, last: l, full: f, data: d, gnt: g, ack: a,
              wr: w, fdata: fd, drop: 1'b0, maxl: 1'b0};
        return t;
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic f,
                         input logic [31:0] d);
        @(negedge clk);
        req       = r;
        last      = l;
        fifo_full = f;
        data      = d;
        #1;
    endtask

    task automatic expect_o(input string nm, input logic [3:0] g, input logic [3:0] a,
                            input logic w, input logic dr, input logic mx, input logic [7:0] d);
        check(nm, act_vec(), mk_exp(g, a, w, dr, mx, d));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        last      = '0;
        fifo_full = 1'b0;
        data      = '0;
        repeat (2) @(negedge clk);
        #1;
        expect_o("reset_state", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit bit_of(logic [3:0] x, int i);
        return x[2'(i)];
    endfunction

    // ------------------------------------------------------------ reference model
    // Arbiter described at packet level: owner = -1 when nobody holds the port.
    int m_owner, m_served, m_beats;
    bit m_drop, m_max;

    task automatic model_reset();
        m_owner  = -1;
        m_served = NREQ - 1;
        m_beats  = 0;
        m_drop   = 1'b0;
        m_max    = 1'b0;
    endtask

    function automatic logic [31:0] model_out(logic [3:0] r, logic f, logic [31:0] d);
        logic [3:0] g, a;
        logic       w;
        logic [7:0] fd;
        g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        w  = (m_owner >= 0) && bit_of(r, m_owner) && !f;
        a  = w ? g : 4'b0;
        fd = w ? d[m_owner*8 +: 8] : 8'h00;
        return mk_exp(g, a, w, m_drop, m_max, fd);
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic f);
        m_drop = 1'b0;
        m_max  = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (m_owner < 0 && bit_of(r, (m_served + k) % NREQ)) begin
                    m_owner = (m_served + k) % NREQ;
                    m_beats = 0;
                end
            end
        end else if (!bit_of(r, m_owner)) begin
            m_drop   = 1'b1;
            m_served = m_owner;
            m_owner  = -1;
        end else if (!f) begin
            m_beats++;
            if (bit_of(l, m_owner)) begin
                m_served = m_owner;
                m_owner  = -1;
            end else if (m_beats == MAXLEN) begin
                m_max    = 1'b1;
                m_served = m_owner;
                m_owner  = -1;
            end
        end
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------ test
    initial begin
        int wr_cnt;
        logic [3:0] r_req, r_last;
        logic       r_full;
        logic [31:0] r_data, exp;

        rst = 1'b1; req = '0; last = '0; fifo_full = 1'b0; data = '0;

        // Single 3-beat packet from requester 0.
        tbl.push_back(v(1, 4'b0001, 4'b0000, 0, mk(0, 8'hA1), 4'b0000, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 4'b0001, 4'b0000, 0, mk(0, 8'hA1), 4'b0001, 4'b0001, 1, 8'hA1));
        tbl.push_back(v(0, 4'b0001, 4'b0000, 0, mk(0, 8'hA2), 4'b0001, 4'b0001, 1, 8'hA2));
        tbl.push_back(v(0, 4'b0001, 4'b0001, 0, mk(0, 8'hA3), 4'b0001, 4'b0001, 1, 8'hA3));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 32'h0,        4'b0000, 4'b0000, 0, 8'h00));
        // All four requesting single-beat packets: order 0,1,2,3,0 with bubbles.
        tbl.push_back(v(1, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0001, 4'b0001, 1, 8'h11));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0010, 4'b0010, 1, 8'h22));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0100, 4'b0100, 1, 8'h33));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b1000, 4'b1000, 1, 8'h44));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0001, 4'b0001, 1, 8'h11));

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            drive(tbl[i].req, tbl[i].last, tbl[i].full, tbl[i].data);
            check($sformatf("vec%0d", i), act_vec(),
                  mk_exp(tbl[i].gnt, tbl[i].ack, tbl[i].wr, tbl[i].drop, tbl[i].maxl, tbl[i].fdata));
        end

        // FIFO full stalls owner 2 for three cycles; the stalled beat goes once.
        do_reset();
        drive(4'b0100, 4'b0000, 0, mk(2, 8'hB1)); expect_o("full_idle",  4'b0000, 4'b0000, 0, 0, 0, 8'h00);
        drive(4'b0100, 4'b0000, 0, mk(2, 8'hB1)); expect_o("full_beat1", 4'b0100, 4'b0100, 1, 0, 0, 8'hB1);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 4'b0100, 1, mk(2, 8'hB2));
            expect_o($sformatf("full_stall%0d", i), 4'b0100, 4'b0000, 0, 0, 0, 8'h00);
        end
        drive(4'b0100, 4'b0100, 0, mk(2, 8'hB2)); expect_o("full_beat2", 4'b0100, 4'b0100, 1, 0, 0, 8'hB2);
        drive(4'b0000, 4'b0000, 0, mk(2, 8'hB3)); expect_o("full_done",  4'b0000, 4'b0000, 0, 0, 0, 8'h00);

        // Owner 1 drops its request after two beats; requester 2 follows.
        do_reset();
        drive(4'b0010, 4'b0000, 0, mk(1, 8'hC1)); expect_o("drop_idle",  4'b0000, 4'b0000, 0, 0, 0, 8'h00);
        drive(4'b0110, 4'b0000, 0, mk(1, 8'hC1)); expect_o("drop_beat1", 4'b0010, 4'b0010, 1, 0, 0, 8'hC1);
        drive(4'b0110, 4'b0000, 0, mk(1, 8'hC2)); expect_o("drop_beat2", 4'b0010, 4'b0010, 1, 0, 0, 8'hC2);
        drive(4'b0100, 4'b0000, 0, mk(1, 8'hC3)); expect_o("drop_nowr",  4'b0010, 4'b0000, 0, 0, 0, 8'h00);
        drive(4'b0100, 4'b0100, 0, mk(2, 8'hD1)); expect_o("drop_pulse", 4'b0000, 4'b0000, 0, 1, 0, 8'h00);
        drive(4'b0100, 4'b0100, 0, mk(2, 8'hD1)); expect_o("drop_next",  4'b0100, 4'b0100, 1, 0, 0, 8'hD1);
        drive(4'b0000, 4'b0000, 0, 32'h0);        expect_o("drop_done",  4'b0000, 4'b0000, 0, 0, 0, 8'h00);

        // Owner 0 never sends last: forced release after exactly MAXLEN writes.
        do_reset();
        wr_cnt = 0;
        drive(4'b0011, 4'b0000, 0, mk(0, 8'h00)); expect_o("max_idle", 4'b0000, 4'b0000, 0, 0, 0, 8'h00);
        for (int b = 0; b < MAXLEN; b++) begin
            drive(4'b0011, 4'b0000, 0, mk(0, 8'(b + 1)));
            if (fifo_wr_en) wr_cnt++;
            expect_o($sformatf("max_beat%0d", b), 4'b0001, 4'b0001, 1, 0, 0, 8'(b + 1));
        end
        drive(4'b0011, 4'b0010, 0, mk(1, 8'hF0));
        if (fifo_wr_en) wr_cnt++;
        expect_o("max_pulse", 4'b0000, 4'b0000, 0, 0, 1, 8'h00);
        check("max_count", 32'(wr_cnt), 32'(MAXLEN));
        drive(4'b0011, 4'b0010, 0, mk(1, 8'hF0)); expect_o("max_next", 4'b0010, 4'b0010, 1, 0, 0, 8'hF0);
        drive(4'b0000, 4'b0000, 0, 32'h0);        expect_o("max_done", 4'b0000, 4'b0000, 0, 0, 0, 8'h00);

        // Reset during beat 2 of a 5-beat packet.
        do_reset();
        drive(4'b0001, 4'b0000, 0, mk(0, 8'h51)); expect_o("rst_idle",  4'b0000, 4'b0000, 0, 0, 0, 8'h00);
        drive(4'b0001, 4'b0000, 0, mk(0, 8'h51)); expect_o("rst_beat1", 4'b0001, 4'b0001, 1, 0, 0, 8'h51);
        drive(4'b0001, 4'b0000, 0, mk(0, 8'h52)); expect_o("rst_beat2", 4'b0001, 4'b0001, 1, 0, 0, 8'h52);
        rst = 1'b1;
        #1;
        expect_o("rst_immediate", 4'b0000, 4'b0000, 0, 0, 0, 8'h00);
        @(negedge clk); #1;
        expect_o("rst_hold", 4'b0000, 4'b0000, 0, 0, 0, 8'h00);
        rst = 1'b0;
        req = 4'b1010;
        drive(4'b1010, 4'b0010, 0, mk(1, 8'h61)); expect_o("rst_regrant", 4'b0010, 4'b0010, 1, 0, 0, 8'h61);
        drive(4'b0000, 4'b0000, 0, 32'h0);        expect_o("rst_done",    4'b0000, 4'b0000, 0, 0, 0, 8'h00);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        r_req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 15) == 0) r_req[i] = ~r_req[i];
                r_last[i] = ($urandom_range(0, 7) == 0);
            end
            r_full = ($urandom_range(0, 4) == 0);
            r_data = $urandom;
            drive(r_req, r_last, r_full, r_data);
            exp = model_out(r_req, r_full, r_data);
            check($sformatf("rand%0d", c), act_vec(), exp);
            model_step(r_req, r_last, r_full);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
